alu_rs: RTL
===========

# alu_rs

Reservation station for the integer ALU in the Tomasulo core. Holds up to DEPTH dispatched ALU instructions and snoops the common data bus (CDB) to resolve pending source operands. Issues the oldest ready instruction each cycle to the registered one-cycle ALU that sits directly downstream. Emits the destination tag aligned with the ALU result so the CDB driver can pair the result with its tag.

## Interface
- DEPTH, 4, number of entries (2..8)
- TAG_W, 4, ROB/physical tag width
- XLEN, 32, operand width
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- flush  in  1  synchronous squash of all entries and in-flight issue
- disp_valid  in  1  dispatch request
- disp_ready  out  1  at least one free entry
- disp_op  in  8  one-hot ALU op: bit0 add/sub, 1 sll, 2 slt, 3 sltu, 4 xor, 5 srl/sra, 6 or, 7 and
- disp_funct7_flag  in  1  selects sub/sra
- disp_dest_tag  in  TAG_W  destination tag
- disp_q1_pend, disp_q2_pend  in  1  operand still waiting on a tag
- disp_q1_tag, disp_q2_tag  in  TAG_W  producer tag when pending
- disp_v1, disp_v2  in  XLEN  operand value when not pending
- cdb_valid  in  1  broadcast valid
- cdb_tag  in  TAG_W  broadcast tag
- cdb_data  in  XLEN  broadcast value
- alu_in1, alu_in2  out  XLEN  registered operands to ALU
- alu_op  out  8  registered op to ALU
- alu_funct7_flag  out  1  registered to ALU
- res_valid  out  1  ALU result valid this cycle
- res_tag  out  TAG_W  tag for current ALU result

## Operation
- Entry state: busy, op, funct7_flag, dest_tag, per operand {pend, tag, value}.
- Dispatch: accepted when disp_valid && disp_ready && !flush; written into the lowest-index free entry.
- Dispatch bypass: if an operand is pending and cdb_valid with cdb_tag equal to its tag in the same cycle, the entry stores cdb_data with pend=0.
- Wakeup: every busy entry compares each pending tag against cdb_tag when cdb_valid; on match stores cdb_data and clears pend at the edge.
- Ready: busy && !q1.pend && !q2.pend, evaluated on registered state.
- Select: oldest ready entry by age matrix; age set at dispatch (new entry younger than all busy entries).
- Issue: at the edge, selected entry's fields loaded into alu_* registers, busy cleared. No ready entry: alu_* hold their values, internal issue-valid = 0.
- res_valid/res_tag: issue-valid and dest_tag delayed one register stage, matching the ALU's one-cycle registered result.
- No backpressure from downstream; the CDB path always accepts res_valid.
- disp_op is stored and forwarded unmodified; non-one-hot values are not checked.

## Timing
- Reset (rst low): all entries free, age matrix cleared, alu_in1/alu_in2/alu_op/alu_funct7_flag = 0, res_valid = 0, res_tag = 0; disp_ready = 1.
- disp_ready combinational from registered busy bits; an entry freed by issue at edge E is visible as free after E.
- Minimum latency: dispatch with both operands ready at edge E -> issue at E+1 -> res_valid high in cycle after E+2.
- Pending operand woken at edge W -> earliest issue at W+1.
- Full: disp_ready = 0; disp_valid ignored.
- Simultaneous issue and dispatch: allowed; dispatch uses a slot free before the edge.
- Simultaneous CDB match on both operands of one entry: both captured.
- flush at edge F: all busy cleared, issue-valid and res_valid forced 0 after F; dispatch in that cycle dropped; alu_* data need not change.
- rst mid-operation: immediate return to reset values.

## Structure
- Shared package alu_pkg: op one-hot bit positions (OP_ADDSUB..OP_AND), TAG_W/XLEN defaults, rs entry struct type.
- Sub-module rs_age_matrix: DEPTH x DEPTH age bits; inputs alloc one-hot, free one-hot, ready vector; output oldest-ready one-hot grant.

## Test plan
- Reset, dispatch add v1=5 v2=7 tag=3, both ready -> alu_in1=5, alu_in2=7, alu_op=8'h01 after next edge; res_valid=1, res_tag=3 one cycle later.
- Dispatch xor with q1 pending on tag 9; CDB tag 9 data 0xFF two cycles later -> issue one cycle after the broadcast with alu_in1=0xFF.
- Dispatch with q2 pending tag 2 while cdb_valid tag 2 data 0x10 in the same cycle -> entry ready immediately, alu_in2=0x10.
- Fill 4 entries all pending, wake in reverse order -> disp_ready=0 while full; each issues in wake order; simultaneous wake of entries 0 and 3 -> older dispatch issues first.
- flush with 3 busy entries and one issue in flight -> res_valid=0 next cycle, disp_ready=1, no later issue.
- Assert rst low mid-stream -> res_valid=0, alu_op=0 immediately; no issue after release until new dispatch.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the integer ALU reservation station.
// Op one-hot positions, default widths and the entry layout.
package alu_pkg;

    localparam int OP_W      = 8;
    localparam int OP_ADDSUB = 0;
    localparam int OP_SLL    = 1;
    localparam int OP_SLT    = 2;
    localparam int OP_SLTU   = 3;
    localparam int OP_XOR    = 4;
    localparam int OP_SRX    = 5;
    localparam int OP_OR     = 6;
    localparam int OP_AND    = 7;

    localparam int RS_TAG_W = 4;
    localparam int RS_XLEN  = 32;

    typedef logic [OP_W-1:0] alu_op_t;

    typedef struct packed {
        logic                pend;
        logic [RS_TAG_W-1:0] tag;
        logic [RS_XLEN-1:0]  val;
    } rs_opnd_t;

    typedef struct packed {
        logic                busy;
        alu_op_t             op;
        logic                f7;
        logic [RS_TAG_W-1:0] dest;
        rs_opnd_t            q1;
        rs_opnd_t            q2;
    } rs_entry_t;

    // A pending operand whose producer tag is on the CDB takes the value.
    function automatic rs_opnd_t snoop(
        input rs_opnd_t            o,
        input logic                cv,
        input logic [RS_TAG_W-1:0] ct,
        input logic [RS_XLEN-1:0]  cd
    );
        rs_opnd_t r;
        r = o;
        if (cv && o.pend && (o.tag == ct)) begin
            r.pend = 1'b0;
            r.val  = cd;
        end
        return r;
    endfunction

endpackage

// File: rtl/rs_age_matrix.sv
// Age matrix for the reservation station.
// Grants the oldest ready entry; older_q[i][j] means i is older than j.
module rs_age_matrix #(
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [DEPTH-1:0] alloc_i,
    input  logic [DEPTH-1:0] free_i,
    input  logic [DEPTH-1:0] ready_i,
    output logic [DEPTH-1:0] grant_o
);

    logic [DEPTH-1:0] older_q [DEPTH];
    logic [DEPTH-1:0] older_d [DEPTH];

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            older_d[i] = older_q[i];
        end
        for (int i = 0; i < DEPTH; i++) begin
            for (int j = 0; j < DEPTH; j++) begin
                if (free_i[i] || free_i[j]) begin
                    older_d[i][j] = 1'b0;
                end
            end
        end
        // A new entry is younger than everything; stale rows of free
        // entries are harmless since they never request and get wiped.
        for (int k = 0; k < DEPTH; k++) begin
            if (alloc_i[k]) begin
                older_d[k] = '0;
                for (int i = 0; i < DEPTH; i++) begin
                    if (i != k) begin
                        older_d[i][k] = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        grant_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            grant_o[i] = ready_i[i];
            for (int j = 0; j < DEPTH; j++) begin
                if (ready_i[j] && older_q[j][i]) begin
                    grant_o[i] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                older_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                older_q[i] <= older_d[i];
            end
        end
    end

endmodule

// File: rtl/alu_rs.sv
// Integer ALU reservation station with CDB snooping.
// Issues the oldest ready entry into registered ALU operand stage.
module alu_rs
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = RS_TAG_W,
    parameter int XLEN  = RS_XLEN
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             disp_valid,
    output logic             disp_ready,
    input  logic [7:0]       disp_op,
    input  logic             disp_funct7_flag,
    input  logic [TAG_W-1:0] disp_dest_tag,
    input  logic             disp_q1_pend,
    input  logic             disp_q2_pend,
    input  logic [TAG_W-1:0] disp_q1_tag,
    input  logic [TAG_W-1:0] disp_q2_tag,
    input  logic [XLEN-1:0]  disp_v1,
    input  logic [XLEN-1:0]  disp_v2,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_tag,
    input  logic [XLEN-1:0]  cdb_data,
    output logic [XLEN-1:0]  alu_in1,
    output logic [XLEN-1:0]  alu_in2,
    output logic [7:0]       alu_op,
    output logic             alu_funct7_flag,
    output logic             res_valid,
    output logic [TAG_W-1:0] res_tag
);

    rs_entry_t ent_q [DEPTH];
    rs_entry_t ent_d [DEPTH];
    rs_entry_t new_ent;
    rs_entry_t sel_ent;
    rs_opnd_t  d1;
    rs_opnd_t  d2;

    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] rdy;
    logic [DEPTH-1:0] free_oh;
    logic [DEPTH-1:0] alloc;
    logic [DEPTH-1:0] grant;
    logic [DEPTH-1:0] release_v;
    logic             disp_fire;
    logic             any_grant;

    logic             iss_v_q;
    logic             res_v_q;
    logic [TAG_W-1:0] iss_tag_q;
    logic [TAG_W-1:0] res_tag_q;
    logic [XLEN-1:0]  in1_q;
    logic [XLEN-1:0]  in2_q;
    alu_op_t          op_q;
    logic             f7_q;

    always_comb begin
        busy = '0;
        rdy  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            busy[i] = ent_q[i].busy;
            rdy[i]  = ent_q[i].busy & ~ent_q[i].q1.pend
                    & ~ent_q[i].q2.pend;
        end
    end

    always_comb begin
        logic found;
        found   = 1'b0;
        free_oh = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!busy[i] && !found) begin
                free_oh[i] = 1'b1;
                found      = 1'b1;
            end
        end
    end

    assign disp_ready = |(~busy);
    assign disp_fire  = disp_valid & disp_ready & ~flush;
    assign alloc      = disp_fire ? free_oh : '0;
    assign release_v  = flush ? '1 : grant;
    assign any_grant  = |grant;

    rs_age_matrix #(
        .DEPTH (DEPTH)
    ) u_age (
        .clk_i   (clk),
        .rst_ni  (rst),
        .alloc_i (alloc),
        .free_i  (release_v),
        .ready_i (rdy),
        .grant_o (grant)
    );

    assign d1 = {disp_q1_pend, disp_q1_tag, disp_v1};
    assign d2 = {disp_q2_pend, disp_q2_tag, disp_v2};

    // Same-cycle CDB bypass for operands arriving with the dispatch.
    always_comb begin
        new_ent      = '0;
        new_ent.busy = 1'b1;
        new_ent.op   = disp_op;
        new_ent.f7   = disp_funct7_flag;
        new_ent.dest = disp_dest_tag;
        new_ent.q1   = snoop(d1, cdb_valid, cdb_tag, cdb_data);
        new_ent.q2   = snoop(d2, cdb_valid, cdb_tag, cdb_data);
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_d[i]    = ent_q[i];
            ent_d[i].q1 = snoop(ent_q[i].q1, cdb_valid, cdb_tag, cdb_data);
            ent_d[i].q2 = snoop(ent_q[i].q2, cdb_valid, cdb_tag, cdb_data);
            if (grant[i]) begin
                ent_d[i].busy = 1'b0;
            end
            if (alloc[i]) begin
                ent_d[i] = new_ent;
            end
            if (flush) begin
                ent_d[i].busy = 1'b0;
            end
        end
    end

    always_comb begin
        sel_ent = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (grant[i]) begin
                sel_ent = ent_q[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= ent_d[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            iss_v_q   <= 1'b0;
            res_v_q   <= 1'b0;
            iss_tag_q <= '0;
            res_tag_q <= '0;
            in1_q     <= '0;
            in2_q     <= '0;
            op_q      <= '0;
            f7_q      <= 1'b0;
        end else begin
            res_tag_q <= iss_tag_q;
            if (flush) begin
                iss_v_q <= 1'b0;
                res_v_q <= 1'b0;
            end else begin
                iss_v_q <= any_grant;
                res_v_q <= iss_v_q;
                if (any_grant) begin
                    in1_q     <= sel_ent.q1.val;
                    in2_q     <= sel_ent.q2.val;
                    op_q      <= sel_ent.op;
                    f7_q      <= sel_ent.f7;
                    iss_tag_q <= sel_ent.dest;
                end
            end
        end
    end

    assign alu_in1         = in1_q;
    assign alu_in2         = in2_q;
    assign alu_op          = op_q;
    assign alu_funct7_flag = f7_q;
    assign res_valid       = res_v_q;
    assign res_tag         = res_tag_q;

endmodule
